hmac_key_padder: RTL and testbench
==================================

# hmac_key_padder

Parametrised HMAC key-pad generator for the HMAC-SHA1 datapath. On `start` it captures a key, a valid-key-length and a pad mode (ipad 0x36 / opad 0x5C). It then streams one block of `BLOCK_WORDS` padded words to the SHA core over a valid/ready interface. It is the next generation of the fixed 32-bit, ipad-only, free-running key padder, adding:

- selectable opad mode,
- short-key zero fill,
- back-pressure,
- abort,
- a completion pulse.

## Interface

Parameters:

- `WORD_W`, 32, output word width in bits; must be a multiple of 8.
- `BLOCK_WORDS`, 16, words per hash block; must be at least 2.
- `KEY_W`, `WORD_W*BLOCK_WORDS`, derived localparam giving the key bus width.
- `CNT_W`, `$clog2(BLOCK_WORDS+1)`, derived localparam giving the width of the word counter and `key_words`.

Ports. One clock; reset is asynchronous and active-low.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `key`  in  `KEY_W`  HMAC key; word i = `key[i*WORD_W +: WORD_W]`.
- `key_words`  in  `CNT_W`  number of valid key words. Words at index ≥ `key_words` are treated as zero. Values above `BLOCK_WORDS` saturate to `BLOCK_WORDS`.
- `mode`  in  1  0 = ipad (0x36), 1 = opad (0x5C).
- `start`  in  1  request a block; sampled only in IDLE.
- `abort`  in  1  synchronous cancel.
- `out_ready`  in  1  SHA core can accept a word.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  `WORD_W`  padded word.
- `out_last`  out  1  marks the final word of the block.
- `busy`  out  1  high in SEND.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation

- FSM states: IDLE and SEND.
- **IDLE, `start`=1 and `abort`=0:**
  - Register `key`, `mode` and saturated `key_words` into the capture registers.
  - Clear the word index to 0.
  - Load `out_data` with word 0 and set `out_valid`=1.
  - Go to SEND.
- **Pad byte:** P = 0x36 if `mode`=0, else 0x5C. The pad word is P replicated `WORD_W/8` times.
- **Word generation:** word i = captured key word i XOR pad word if i < captured `key_words`; otherwise it is the pad word alone.
- **Handshake:** a transfer occurs when `out_valid`&&`out_ready`.
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
  - On a transfer of word i < `BLOCK_WORDS`-1, the index becomes i+1 and `out_data` loads word i+1 in the same edge. There are no bubbles.
- **`out_last`:** high exactly when `out_valid`=1 and the index = `BLOCK_WORDS`-1.
- **Last-word transfer:** go to IDLE, drop `out_valid` and `out_last`, pulse `done` for 1 cycle.
- **`abort`=1 in SEND:** go to IDLE next edge, drop `out_valid`, `out_last` and `busy`. `done` is not asserted. If `abort` coincides with the last transfer, `abort` wins: no `done`.
- **`abort`=1 in IDLE:** no effect, and blocks `start` that cycle.
- **`start` in SEND:** ignored, with no queuing.
- **Input stability:** `key`, `key_words` and `mode` may change freely after the `start` cycle; only the captured copies are used.
- **Arithmetic:** the index is `CNT_W` wide and never wraps past `BLOCK_WORDS`-1.

## Timing

- **Reset values:** state=IDLE; `out_valid`, `out_last`, `busy` and `done` = 0; `out_data`=0; index and capture registers = 0.
- **Reset mid-block:** all outputs go to their reset values immediately (asynchronously). The block is abandoned.
- **Start latency:** `start` sampled at edge t gives `out_valid`=1 with word 0 after edge t (cycle t+1).
- **Throughput:** with `out_ready` held high, words 0..`BLOCK_WORDS`-1 appear in cycles t+1..t+`BLOCK_WORDS`. `done`=1 in cycle t+`BLOCK_WORDS`+1.
- **Back-to-back blocks:** a new `start` is accepted in the same cycle `done` is high. The next word 0 follows one cycle later, so there is a one-cycle gap between blocks.
- **Output timing:** all outputs are registered; there is no combinational path from `out_ready` to `out_data`.

## Test plan

- **All-zero key, ipad:** reset, `key`=0, `key_words`=16, `mode`=0, `start` pulse, `out_ready`=1 → 16 words of 0x36363636. `out_last` is high on word 15 only. `done` pulses once at t+17.
- **Partial key, opad:** word0=0x01234567, word1=0xFFFFFFFF, all other words 0xDEADBEEF, `key_words`=2, `mode`=1 →
  - word0 = 0x5D7F193B,
  - word1 = 0xA3A3A3A3,
  - words 2..15 = 0x5C5C5C5C.
  
  Repeat with `key_words`=31: it saturates to 16 and words 2..15 = 0x82F1E2B3.
- **Back-pressure:** toggle `out_ready` with a pseudo-random pattern → exactly 16 transfers in order, `out_data` stable while stalled, no duplicates or drops. `start` pulses during SEND are ignored.
- **Abort:** `abort` at word 7 → `out_valid`=0 next cycle with no `done`. A fresh `start` then restarts at word 0. Also assert `abort` during the word-15 transfer → no `done`.
- **Reset mid-block:** deassert `rst_n` at word 5 → all outputs 0 asynchronously. After release, a `start` produces a full correct block.
- **Parameter sweep:** `WORD_W`=64, `BLOCK_WORDS`=8, zero key, opad → 8 words of 0x5C5C5C5C5C5C5C5C, with `out_last` on word 7.

Source files
------------

// File: rtl/hmac_key_padder.sv
// HMAC key-pad generator: captures a key on start and streams one block of
// key-XOR-pad words (ipad 0x36 / opad 0x5C) over a valid/ready interface.
module hmac_key_padder #(
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 16,
    localparam int KEY_W      = WORD_W * BLOCK_WORDS,
    localparam int CNT_W      = $clog2(BLOCK_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key,
    input  logic [CNT_W-1:0]  key_words,
    input  logic              mode,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_WORDS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [CNT_W-1:0]    nwords_q, nwords_d;
    logic                mode_q, mode_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    nwords_sat;

    // Word idx of the padded block; key words at or beyond nwords read as zero.
    function automatic logic [WORD_W-1:0] padded_word(
        input logic [KEY_W-1:0] k,
        input logic [CNT_W-1:0] nwords,
        input logic             m,
        input logic [CNT_W-1:0] idx
    );
        logic [WORD_W-1:0] kword;
        logic [7:0]        pad_byte;
        pad_byte = m ? 8'h5C : 8'h36;
        kword    = '0;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            if (CNT_W'(w) == idx && idx < nwords) begin
                kword = k[w*WORD_W +: WORD_W];
            end
        end
        return kword ^ {(WORD_W/8){pad_byte}};
    endfunction

    assign nwords_sat = (key_words > FULL_CNT) ? FULL_CNT : key_words;

    always_comb begin
        // NOTE: every next-state signal gets a hold/default value first so no
        // path through the case below can leave one unassigned (no latches).
        state_d  = state_q;
        idx_d    = idx_q;
        key_d    = key_q;
        nwords_d = nwords_q;
        mode_d   = mode_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    key_d    = key;
                    nwords_d = nwords_sat;
                    mode_d   = mode;
                    idx_d    = '0;
                    data_d   = padded_word(key, nwords_sat, mode, '0);
                    valid_d  = 1'b1;
                    last_d   = 1'b0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else if (valid_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Next word is loaded on the accepting edge: no bubbles.
                        idx_d  = idx_q + 1'b1;
                        data_d = padded_word(key_q, nwords_q, mode_q, idx_q + 1'b1);
                        last_d = (idx_q + 1'b1 == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            key_q    <= '0;
            nwords_q <= '0;
            mode_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            key_q    <= key_d;
            nwords_q <= nwords_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = (state_q == SEND);
    assign done      = done_q;

endmodule

// File: tb/tb_hmac_key_padder.sv
// Self-checking bench for hmac_key_padder: default 32x16 instance plus a
// 64x8 instance, checked against a byte-level reference model.
module tb_hmac_key_padder;

    logic clk;
    logic rst_n;

    // 32-bit x 16-word instance
    logic [511:0] key;
    logic [4:0]   key_words;
    logic         mode, start, abort, out_ready;
    logic         out_valid, out_last, busy, done;
    logic [31:0]  out_data;

    // 64-bit x 8-word instance
    logic [511:0] key64;
    logic [3:0]   key_words64;
    logic         mode64, start64, abort64, out_ready64;
    logic         out_valid64, out_last64, busy64, done64;
    logic [63:0]  out_data64;

    int checks = 0;
    int errors = 0;

    hmac_key_padder #(.WORD_W(32), .BLOCK_WORDS(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_words(key_words), .mode(mode),
        .start(start), .abort(abort), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    hmac_key_padder #(.WORD_W(64), .BLOCK_WORDS(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .key(key64), .key_words(key_words64), .mode(mode64),
        .start(start64), .abort(abort64), .out_ready(out_ready64), .out_valid(out_valid64),
        .out_data(out_data64), .out_last(out_last64), .busy(busy64), .done(done64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: each byte of word i is the pad byte, XORed with the matching
    // key byte when i is below the (saturated) key length.
    function automatic logic [63:0] model_word(input logic [511:0] k, input int kw,
                                               input bit m, input int i,
                                               input int ww, input int bw);
        int         eff;
        logic [7:0] p, kb;
        logic [63:0] w;
        eff = (kw > bw) ? bw : kw;
        p   = m ? 8'h5C : 8'h36;
        w   = '0;
        for (int b = 0; b < ww / 8; b++) begin
            kb = (i < eff) ? k[i*ww + b*8 +: 8] : 8'h00;
            w[b*8 +: 8] = kb ^ p;
        end
        return w;
    endfunction

    function automatic logic [511:0] rand_key();
        logic [511:0] k;
        for (int i = 0; i < 16; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    // Full block on the 32x16 instance. Ends in the cycle where done is high,
    // so a following call exercises back-to-back start.
    task automatic run_block(input logic [511:0] k, input int kw, input bit m, input bit bp);
        logic [63:0] expw [16];
        logic [31:0] prev_data;
        logic        prev_last, stalled, r;
        int          n, cyc;
        for (int i = 0; i < 16; i++) expw[i] = model_word(k, kw, m, i, 32, 16);
        key = k; key_words = kw[4:0]; mode = m; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        key = rand_key(); key_words = 5'($urandom); mode = 1'($urandom);
        check("done_low_after_start", {63'd0, done}, 64'd0);
        n = 0; cyc = 0; stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
        while (n < 16 && cyc < 400) begin
            check("valid_busy", {62'd0, out_valid, busy}, 64'd3);
            if (stalled) begin
                check("stall_data_stable", {32'd0, out_data}, {32'd0, prev_data});
                check("stall_last_stable", {63'd0, out_last}, {63'd0, prev_last});
            end
            r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            start = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            if (r) begin
                check($sformatf("word%0d", n), {32'd0, out_data}, expw[n]);
                check($sformatf("last%0d", n), {63'd0, out_last}, {63'd0, n == 15});
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev_data = out_data;
                prev_last = out_last;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b0;
        check("transfer_count", 64'(n), 64'd16);
        if (!bp) check("throughput_cycles", 64'(cyc), 64'd16);
        check("done_pulse", {60'd0, done, out_valid, out_last, busy}, 64'h8);
    endtask

    // Start a block, stream up to word k_idx, then abort while word k_idx is offered.
    task automatic abort_at(input int k_idx);
        logic [511:0] k;
        int           kw;
        bit           m;
        k = rand_key(); kw = $urandom_range(0, 31); m = 1'($urandom);
        key = k; key_words = kw[4:0]; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        repeat (k_idx) @(negedge clk);
        check($sformatf("abort_word%0d", k_idx), {32'd0, out_data}, model_word(k, kw, m, k_idx, 32, 16));
        check("abort_last_flag", {63'd0, out_last}, {63'd0, k_idx == 15});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        check("after_abort", {60'd0, done, out_valid, out_last, busy}, 64'd0);
        @(negedge clk);
        check("no_done_after_abort", {63'd0, done}, 64'd0);
    endtask

    task automatic run_block64(input logic [511:0] k, input int kw, input bit m);
        key64 = k; key_words64 = kw[3:0]; mode64 = m; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0; out_ready64 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("w64_valid", {63'd0, out_valid64}, 64'd1);
            check($sformatf("w64_word%0d", i), out_data64, model_word(k, kw, m, i, 64, 8));
            check($sformatf("w64_last%0d", i), {63'd0, out_last64}, {63'd0, i == 7});
            @(negedge clk);
        end
        out_ready64 = 1'b0;
        check("w64_done", {60'd0, done64, out_valid64, out_last64, busy64}, 64'h8);
    endtask

    initial begin
        logic [511:0] k;
        rst_n = 1'b0;
        key = '0; key_words = '0; mode = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        key64 = '0; key_words64 = '0; mode64 = 1'b0; start64 = 1'b0; abort64 = 1'b0; out_ready64 = 1'b0;

        // Reset state
        #12;
        check("reset_ctrl", {60'd0, out_valid, out_last, busy, done}, 64'd0);
        check("reset_data", {32'd0, out_data}, 64'd0);
        check("reset_ctrl64", {60'd0, out_valid64, out_last64, busy64, done64}, 64'd0);
        check("reset_data64", out_data64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero key, ipad
        run_block('0, 16, 1'b0, 1'b0);

        // Partial key, opad, then the same key with an over-long length (back-to-back)
        k = {16{32'hDEADBEEF}};
        k[31:0]  = 32'h01234567;
        k[63:32] = 32'hFFFFFFFF;
        run_block(k, 2, 1'b1, 1'b0);
        run_block(k, 31, 1'b1, 1'b0);
        @(negedge clk);
        check("done_single_cycle", {63'd0, done}, 64'd0);

        // Random keys under back-pressure with start pulses during SEND
        for (int t = 0; t < 6; t++) begin
            run_block(rand_key(), $urandom_range(0, 31), 1'($urandom), 1'b1);
            @(negedge clk);
        end

        // Abort in IDLE blocks a simultaneous start
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_blocks_start", {62'd0, out_valid, busy}, 64'd0);
        @(negedge clk);
        check("idle_abort_still_idle", {62'd0, out_valid, busy}, 64'd0);

        // Abort mid-block, restart, abort on the last transfer
        abort_at(7);
        run_block(rand_key(), $urandom_range(0, 31), 1'($urandom), 1'b0);
        @(negedge clk);
        abort_at(15);

        // Asynchronous reset mid-block
        key = rand_key(); key_words = 5'd16; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_reset_busy", {62'd0, out_valid, busy}, 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {60'd0, out_valid, out_last, busy, done}, 64'd0);
        check("async_reset_data", {32'd0, out_data}, 64'd0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(rand_key(), $urandom_range(0, 31), 1'($urandom), 1'b1);
        @(negedge clk);

        // 64-bit x 8-word instance
        run_block64('0, 8, 1'b1);
        @(negedge clk);
        run_block64(rand_key(), $urandom_range(0, 15), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
